keypad_scan_debounce: RTL and testbench



---
 rtl/keypad_scan_debounce_if.sv | 25 ++
 rtl/keypad_scan_debounce.sv | 139 +++++++++++++
 tb/tb_keypad_scan_debounce.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_debounce_if.sv
// Keypad-side and key-event signals of keypad_scan_debounce.
// The master is the scanner; the slave is the keypad plus the key consumer.
interface keypad_scan_debounce_if;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  key_col,
    output key_row,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output key_col,
    input  key_row,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with press/release debounce.
// Emits one key_valid strobe and key_code per physical press.
module keypad_scan_debounce #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEB_CNT  = 20
) (
  input  logic                   clk_50M,
  input  logic                   rst_n,
  keypad_scan_debounce_if.master kif
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEB_CNT + 1);

  localparam logic [1:0] SCAN      = 2'd0;
  localparam logic [1:0] DEB_PRESS = 2'd1;
  localparam logic [1:0] PRESSED   = 2'd2;
  localparam logic [1:0] DEB_REL   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       col_m_q, col_s_q;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             tick;
  logic [3:0]       row_rot;

  // Index of the lowest zero bit; used both for the one-hot-zero row and the column set.
  function automatic logic [1:0] low_zero_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign tick    = (div_q == DIV_W'(SCAN_DIV - 1));
  assign row_rot = {row_q[2:0], row_q[3]};

  // State and datapath registers
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      div_q   <= '0;
      cnt_q   <= '0;
      col_m_q <= 4'hF;
      col_s_q <= 4'hF;
      cand_q  <= 4'hF;
      row_q   <= 4'b1110;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      col_m_q <= kif.key_col;
      col_s_q <= col_m_q;
      cand_q  <= cand_d;
      row_q   <= row_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  // Next-state logic; every decision is gated by the sample tick
  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    row_d   = row_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    cnt_inc = (cnt_q == CNT_W'(DEB_CNT)) ? cnt_q : cnt_q + CNT_W'(1);

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (col_s_q == 4'hF) begin
            row_d = row_rot;
          end else begin
            cand_d  = col_s_q;
            cnt_d   = CNT_W'(1);
            state_d = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (col_s_q == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEB_CNT)) begin
              state_d = PRESSED;
              code_d  = {low_zero_idx(row_q), low_zero_idx(cand_q)};
              valid_d = 1'b1;
              held_d  = 1'b1;
            end
          end else begin
            // Bounce: abandon without rotating so the same row is retried
            cnt_d   = '0;
            state_d = SCAN;
          end
        end
        PRESSED: begin
          if (col_s_q == 4'hF) begin
            cnt_d   = CNT_W'(1);
            state_d = DEB_REL;
          end
        end
        DEB_REL: begin
          if (col_s_q == 4'hF) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DEB_CNT)) begin
              cnt_d   = '0;
              held_d  = 1'b0;
              row_d   = row_rot;
              state_d = SCAN;
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign kif.key_row   = row_q;
  assign kif.key_code  = code_q;
  assign kif.key_valid = valid_q;
  assign kif.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with SCAN_DIV=4, DEB_CNT=3.
// A small keypad model pulls key_col low only while the pressed key's row is driven.
module tb_keypad_scan_debounce;

  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  logic [3:0] row_pat    = 4'h0;
  logic [3:0] press_cols = 4'hF;
  logic [3:0] rows [4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scan_debounce_if kif ();

  keypad_scan_debounce #(
    .SCAN_DIV(4),
    .DEB_CNT (3)
  ) dut (
    .clk_50M(clk_50M),
    .rst_n  (rst_n),
    .kif    (kif)
  );

  assign kif.key_col = (kif.key_row == row_pat) ? press_cols : 4'hF;

  always #5 clk_50M = ~clk_50M;

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk_50M);
      n++;
    end while (!kif.key_valid && n < limit);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50M);
    checks++;
    if (kif.key_row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b expected 1110", kif.key_row); end
    checks++;
    if (kif.key_code !== 4'h0) begin errors++; $display("FAIL reset_code: got %h expected 0", kif.key_code); end
    checks++;
    if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", kif.key_valid); end
    checks++;
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", kif.key_held); end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_50M);
      checks++;
      if (kif.key_row !== rows[(k / 4) % 4]) begin
        errors++;
        $display("FAIL rotate cycle %0d: got %b expected %b", k, kif.key_row, rows[(k / 4) % 4]);
      end
    end
  endtask

  task automatic test_clean_press();
    int n;
    n = 0;
    while (kif.key_row !== 4'b1101 && n < 40) begin
      @(negedge clk_50M);
      n++;
    end
    checks++;
    if (kif.key_row !== 4'b1101) begin errors++; $display("FAIL press_wait_row: got %b expected 1101", kif.key_row); end
    row_pat    = 4'b1101;
    press_cols = 4'b1011;
    wait_valid(40, n);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL press_latency: got %0d cycles expected 12", n); end
    checks++;
    if (kif.key_code !== 4'h6) begin errors++; $display("FAIL press_code: got %h expected 6", kif.key_code); end
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b expected 1", kif.key_held); end
    checks++;
    if (kif.key_row !== 4'b1101) begin errors++; $display("FAIL press_row_frozen: got %b expected 1101", kif.key_row); end
  endtask

  // Release ticks F / low / F / F / F; held drops only after the third clean F tick
  task automatic test_bouncy_release();
    logic [3:0] pat [5]      = '{4'hF, 4'b1011, 4'hF, 4'hF, 4'hF};
    logic       held_exp [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int vcount;
    vcount = 0;
    for (int t = 0; t < 5; t++) begin
      press_cols = pat[t];
      repeat (4) begin
        @(negedge clk_50M);
        if (kif.key_valid) vcount++;
      end
      checks++;
      if (kif.key_held !== held_exp[t]) begin
        errors++;
        $display("FAIL release_held tick %0d: got %b expected %b", t, kif.key_held, held_exp[t]);
      end
      checks++;
      if (kif.key_row !== ((t < 4) ? 4'b1101 : 4'b1011)) begin
        errors++;
        $display("FAIL release_row tick %0d: got %b expected %b", t, kif.key_row, (t < 4) ? 4'b1101 : 4'b1011);
      end
    end
    checks++;
    if (vcount !== 0) begin errors++; $display("FAIL release_extra_valid: got %0d pulses expected 0", vcount); end
    checks++;
    if (kif.key_code !== 4'h6) begin errors++; $display("FAIL release_code_hold: got %h expected 6", kif.key_code); end
  endtask

  task automatic test_short_bounce();
    int vcount;
    vcount     = 0;
    row_pat    = 4'b1011;
    press_cols = 4'b1110;
    repeat (4) begin @(negedge clk_50M); if (kif.key_valid) vcount++; end
    press_cols = 4'hF;
    checks++;
    if (kif.key_row !== 4'b1011) begin errors++; $display("FAIL bounce_row_detect: got %b expected 1011", kif.key_row); end
    repeat (4) begin @(negedge clk_50M); if (kif.key_valid) vcount++; end
    checks++;
    if (kif.key_row !== 4'b1011) begin errors++; $display("FAIL bounce_row_abort: got %b expected 1011", kif.key_row); end
    repeat (4) begin @(negedge clk_50M); if (kif.key_valid) vcount++; end
    checks++;
    if (kif.key_row !== 4'b0111) begin errors++; $display("FAIL bounce_row_resume: got %b expected 0111", kif.key_row); end
    checks++;
    if (vcount !== 0) begin errors++; $display("FAIL bounce_valid: got %0d pulses expected 0", vcount); end
    checks++;
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL bounce_held: got %b expected 0", kif.key_held); end
  endtask

  task automatic test_two_columns();
    int n;
    row_pat    = 4'b0111;
    press_cols = 4'b0110;
    wait_valid(40, n);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL twocol_latency: got %0d cycles expected 12", n); end
    checks++;
    if (kif.key_code !== 4'hC) begin errors++; $display("FAIL twocol_code: got %h expected C", kif.key_code); end
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("FAIL twocol_held: got %b expected 1", kif.key_held); end
    @(negedge clk_50M);
    checks++;
    if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL twocol_pulse_width: got %b expected 0", kif.key_valid); end
  endtask

  // Key 0110 on row 3 stays held across an asynchronous reset
  task automatic test_async_reset();
    int n;
    int vcount;
    repeat (2) @(negedge clk_50M);
    @(posedge clk_50M);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (kif.key_held !== 1'b0) begin errors++; $display("FAIL async_held: got %b expected 0", kif.key_held); end
    checks++;
    if (kif.key_row !== 4'b1110) begin errors++; $display("FAIL async_row: got %b expected 1110", kif.key_row); end
    checks++;
    if (kif.key_code !== 4'h0) begin errors++; $display("FAIL async_code: got %h expected 0", kif.key_code); end
    checks++;
    if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", kif.key_valid); end
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    wait_valid(60, n);
    checks++;
    if (n !== 24) begin errors++; $display("FAIL redetect_latency: got %0d cycles expected 24", n); end
    checks++;
    if (kif.key_code !== 4'hC) begin errors++; $display("FAIL redetect_code: got %h expected C", kif.key_code); end
    checks++;
    if (kif.key_held !== 1'b1) begin errors++; $display("FAIL redetect_held: got %b expected 1", kif.key_held); end
    vcount = 0;
    repeat (40) begin @(negedge clk_50M); if (kif.key_valid) vcount++; end
    checks++;
    if (vcount !== 0) begin errors++; $display("FAIL redetect_repeat: got %0d pulses expected 0", vcount); end
    checks++;
    if (kif.key_row !== 4'b0111) begin errors++; $display("FAIL redetect_row: got %b expected 0111", kif.key_row); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bouncy_release();
    test_short_bounce();
    test_two_columns();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
